// File: rtl/jpeg_us_pkg.sv
// Shared types and channel codes for the chroma upsampler scheduler.
// Blocks are packed as [row][col] of 8-bit samples.
package jpeg_us_pkg;

  typedef logic [3:0][3:0][7:0] blk4_t;
  typedef logic [7:0][7:0][7:0] blk8_t;
  typedef logic [7:0][7:0]      row8_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } us_state_e;

  localparam logic [1:0] CB_CODE = 2'b01;
  localparam logic [1:0] CR_CODE = 2'b10;

endpackage

// File: rtl/chroma_upsample_sched_rr_arb2.sv
// Two-requester round-robin grant; i_mask removes requesters from contention.
// Requester 0 is Cb, requester 1 is Cr; after reset Cr counts as last granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  output logic [1:0] o_gnt
);

  logic       r_last;
  logic [1:0] w_elig;

  assign w_elig = i_req & i_mask;

  always_comb begin
    o_gnt = w_elig;
    if (w_elig == 2'b11) begin
      o_gnt = r_last ? 2'b01 : 2'b10;
    end
  end

  // A grant is always a completed handshake because req already carries valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (|o_gnt) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/chroma_upsample_sched.sv
// Accepts 4x4 Cb/Cr blocks, holds one on the shared upsampler and
// streams its 8x8 result as eight row beats under valid/ready.
module chroma_upsample_sched
  import jpeg_us_pkg::*;
#(
  parameter int         STRICT_PAIR = 1,
  parameter logic [1:0] CB_ID       = CB_CODE,
  parameter logic [1:0] CR_ID       = CR_CODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cb_valid,
  output logic        cb_ready,
  input  blk4_t       cb_block,
  input  logic        cr_valid,
  output logic        cr_ready,
  input  blk4_t       cr_block,
  output logic [1:0]  us_ch,
  output logic        us_valid_in,
  output blk4_t       us_block_in,
  input  blk8_t       us_block_out,
  input  logic        us_valid_out,
  output logic        out_valid,
  input  logic        out_ready,
  output row8_t       out_row,
  output logic [2:0]  out_row_idx,
  output logic [1:0]  out_ch,
  output logic        out_last,
  output logic        busy,
  output logic        err_sticky,
  input  logic        err_clr
);

  us_state_e  r_state;
  logic [2:0] r_row_cnt;
  blk4_t      r_hold;
  logic [1:0] r_hold_ch;
  logic       r_expect_cr;
  logic       r_err;

  logic       w_idle;
  logic       w_emit;
  logic [1:0] w_req;
  logic [1:0] w_mask;
  logic [1:0] w_gnt;

  // Gating with rst_n keeps both readies low while reset is held.
  assign w_idle = (r_state == IDLE) && rst_n;
  assign w_emit = (r_state == EMIT);
  assign w_req  = {cr_valid, cb_valid} & {2{w_idle}};
  assign w_mask = (STRICT_PAIR != 0) ? (r_expect_cr ? 2'b10 : 2'b01) : 2'b11;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (w_req),
    .i_mask (w_mask),
    .o_gnt  (w_gnt)
  );

  assign cb_ready = w_gnt[0];
  assign cr_ready = w_gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_row_cnt   <= 3'd0;
      r_hold      <= '0;
      r_hold_ch   <= CB_ID;
      r_expect_cr <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt[0]) begin
            r_hold    <= cb_block;
            r_hold_ch <= CB_ID;
            r_row_cnt <= 3'd0;
            r_state   <= EMIT;
          end else if (w_gnt[1]) begin
            r_hold    <= cr_block;
            r_hold_ch <= CR_ID;
            r_row_cnt <= 3'd0;
            r_state   <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (r_row_cnt == 3'd7) begin
              r_state   <= IDLE;
              r_row_cnt <= 3'd0;
              if (STRICT_PAIR != 0) begin
                r_expect_cr <= ~r_expect_cr;
              end
            end else begin
              r_row_cnt <= r_row_cnt + 3'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      // A fresh error takes priority over a coincident clear.
      if (w_emit && !us_valid_out) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign us_valid_in = w_emit;
  assign us_ch       = w_emit ? r_hold_ch : 2'b00;
  assign us_block_in = w_emit ? r_hold : '0;
  assign out_valid   = w_emit;
  assign out_row     = w_emit ? us_block_out[r_row_cnt] : '0;
  assign out_row_idx = w_emit ? r_row_cnt : 3'd0;
  assign out_ch      = w_emit ? r_hold_ch : 2'b00;
  assign out_last    = w_emit && (r_row_cnt == 3'd7);
  assign busy        = w_emit;
  assign err_sticky  = r_err;

endmodule
